// File: rtl/sync_word_lock.sv
// Sync word detector and frame aligner.
// Hunts for a sync word of either polarity, confirms it at the frame period,
// then forwards polarity-corrected payload words while tracking lost sync slots.
module sync_word_lock #(
    parameter int                 WIDTH      = 8,
    parameter logic [WIDTH-1:0]   PATTERN    = 8'hA5,
    parameter int                 FRAME_LEN  = 4,
    parameter int                 LOCK_CNT   = 3,
    parameter int                 UNLOCK_CNT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             sof,
    output logic             locked,
    output logic             inverted,
    output logic             lock_lost
);

    localparam int PW = $clog2(FRAME_LEN);
    localparam int HW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(UNLOCK_CNT + 1);

    localparam logic [PW-1:0] POS_ZERO  = {PW{1'b0}};
    localparam logic [PW-1:0] POS_ONE   = PW'(1);
    localparam logic [PW-1:0] POS_LAST  = PW'(FRAME_LEN - 1);
    localparam logic [HW-1:0] HIT_ZERO  = {HW{1'b0}};
    localparam logic [HW-1:0] HIT_ONE   = HW'(1);
    localparam logic [HW-1:0] HIT_LAST  = HW'(LOCK_CNT - 1);
    localparam logic [MW-1:0] MISS_ZERO = {MW{1'b0}};
    localparam logic [MW-1:0] MISS_ONE  = MW'(1);
    localparam logic [MW-1:0] MISS_LAST = MW'(UNLOCK_CNT - 1);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    pos_q, pos_d;
    logic [HW-1:0]    hit_cnt_q, hit_cnt_d;
    logic [MW-1:0]    miss_cnt_q, miss_cnt_d;
    logic             pol_q, pol_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             sof_q, sof_d;
    logic             locked_q, locked_d;
    logic             inverted_q, inverted_d;
    logic             lock_lost_q, lock_lost_d;

    logic             hit_t_s, hit_i_s, match_s, same_s;
    logic [PW-1:0]    pos_inc_s;

    // Decode the incoming word against both polarities and compute the wrapped next position.
    always_comb begin
        hit_t_s   = (din == PATTERN);
        hit_i_s   = (din == ~PATTERN);
        match_s   = hit_t_s | hit_i_s;
        same_s    = pol_q ? hit_i_s : hit_t_s;
        pos_inc_s = (pos_q == POS_LAST) ? POS_ZERO : (pos_q + POS_ONE);
    end

    // Next-state logic: alignment FSM, counters, polarity and payload forwarding.
    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        pol_d        = pol_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        sof_d        = 1'b0;
        locked_d     = locked_q;
        inverted_d   = inverted_q;
        lock_lost_d  = 1'b0;

        if (din_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (match_s) begin
                        pol_d     = hit_i_s;
                        hit_cnt_d = HIT_ONE;
                        pos_d     = POS_ONE;
                        if (LOCK_CNT == 1) begin
                            state_d    = ST_LOCKED;
                            locked_d   = 1'b1;
                            inverted_d = hit_i_s;
                            miss_cnt_d = MISS_ZERO;
                        end else begin
                            state_d = ST_CONFIRM;
                        end
                    end else begin
                        state_d = ST_HUNT;
                    end
                end
                ST_CONFIRM: begin
                    pos_d = pos_inc_s;
                    if (pos_q == POS_ZERO) begin
                        if (same_s) begin
                            if (hit_cnt_q >= HIT_LAST) begin
                                state_d    = ST_LOCKED;
                                locked_d   = 1'b1;
                                inverted_d = pol_q;
                                miss_cnt_d = MISS_ZERO;
                                hit_cnt_d  = HIT_ZERO;
                            end else begin
                                hit_cnt_d = hit_cnt_q + HIT_ONE;
                            end
                        end else if (match_s) begin
                            // Opposite polarity: restart confirmation on this word.
                            pol_d     = hit_i_s;
                            hit_cnt_d = HIT_ONE;
                            pos_d     = POS_ONE;
                        end else begin
                            state_d   = ST_HUNT;
                            hit_cnt_d = HIT_ZERO;
                            pos_d     = POS_ZERO;
                        end
                    end else begin
                        state_d = ST_CONFIRM;
                    end
                end
                ST_LOCKED: begin
                    pos_d = pos_inc_s;
                    if (pos_q == POS_ZERO) begin
                        if (same_s) begin
                            miss_cnt_d = MISS_ZERO;
                        end else if (miss_cnt_q >= MISS_LAST) begin
                            state_d     = ST_HUNT;
                            locked_d    = 1'b0;
                            inverted_d  = 1'b0;
                            lock_lost_d = 1'b1;
                            miss_cnt_d  = MISS_ZERO;
                            hit_cnt_d   = HIT_ZERO;
                            pos_d       = POS_ZERO;
                        end else begin
                            miss_cnt_d = miss_cnt_q + MISS_ONE;
                        end
                    end else begin
                        dout_d       = din ^ {WIDTH{pol_q}};
                        dout_valid_d = 1'b1;
                        sof_d        = (pos_q == POS_ONE);
                    end
                end
                default: begin
                    state_d    = ST_HUNT;
                    pos_d      = POS_ZERO;
                    hit_cnt_d  = HIT_ZERO;
                    miss_cnt_d = MISS_ZERO;
                    locked_d   = 1'b0;
                    inverted_d = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HUNT;
            pos_q        <= POS_ZERO;
            hit_cnt_q    <= HIT_ZERO;
            miss_cnt_q   <= MISS_ZERO;
            pol_q        <= 1'b0;
            dout_q       <= {WIDTH{1'b0}};
            dout_valid_q <= 1'b0;
            sof_q        <= 1'b0;
            locked_q     <= 1'b0;
            inverted_q   <= 1'b0;
            lock_lost_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            pol_q        <= pol_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            sof_q        <= sof_d;
            locked_q     <= locked_d;
            inverted_q   <= inverted_d;
            lock_lost_q  <= lock_lost_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign sof        = sof_q;
    assign locked     = locked_q;
    assign inverted   = inverted_q;
    assign lock_lost  = lock_lost_q;

endmodule

// File: tb/tb_sync_word_lock.sv
// Self-checking bench for sync_word_lock: vector tables, directed corner
// sequences and a randomized framed stream checked against a reference model.
module tb_sync_word_lock;

    localparam logic [7:0] PAT = 8'hA5;
    localparam int FLEN = 4;
    localparam int LCNT = 3;
    localparam int UCNT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din_valid = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       dout_valid, sof, locked, inverted, lock_lost;

    int total = 0;
    int bad   = 0;

    sync_word_lock #(
        .WIDTH(8), .PATTERN(PAT), .FRAME_LEN(FLEN), .LOCK_CNT(LCNT), .UNLOCK_CNT(UCNT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
        .dout(dout), .dout_valid(dout_valid), .sof(sof),
        .locked(locked), .inverted(inverted), .lock_lost(lock_lost)
    );

    always #5 clk = ~clk;

    // Reference model: frame-level view of the stream
    bit         m_lock, m_cand, m_pol;
    int         m_hits, m_miss, m_idx;
    logic [7:0] m_dout;
    bit         e_dv, e_sof, e_ll;

    task automatic model_reset();
        m_lock = 1'b0; m_cand = 1'b0; m_pol = 1'b0;
        m_hits = 0; m_miss = 0; m_idx = 0;
        m_dout = 8'h00; e_dv = 1'b0; e_sof = 1'b0; e_ll = 1'b0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] d);
        bit ht, hi, same;
        int slot;
        e_dv = 1'b0; e_sof = 1'b0; e_ll = 1'b0;
        if (v) begin
            ht = (d == PAT);
            hi = (d == ~PAT);
            same = m_pol ? hi : ht;
            if (!m_lock && !m_cand) begin
                if (ht || hi) begin
                    m_pol = hi; m_hits = 1; m_idx = 1;
                    if (LCNT == 1) begin m_lock = 1'b1; m_miss = 0; end
                    else m_cand = 1'b1;
                end
            end else begin
                slot  = m_idx;
                m_idx = (m_idx + 1) % FLEN;
                if (m_cand) begin
                    if (slot == 0) begin
                        if (same) begin
                            m_hits++;
                            if (m_hits >= LCNT) begin m_cand = 1'b0; m_lock = 1'b1; m_miss = 0; end
                        end else if (ht || hi) begin
                            m_pol = hi; m_hits = 1; m_idx = 1;
                        end else begin
                            m_cand = 1'b0;
                        end
                    end
                end else begin
                    if (slot == 0) begin
                        if (same) m_miss = 0;
                        else begin
                            m_miss++;
                            if (m_miss >= UCNT) begin m_lock = 1'b0; e_ll = 1'b1; end
                        end
                    end else begin
                        e_dv = 1'b1;
                        e_sof = (slot == 1);
                        m_dout = d ^ {8{m_pol}};
                    end
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_cmp(input string tag);
        chk({tag, "_locked"},   locked,     m_lock);
        chk({tag, "_inverted"}, inverted,   m_lock & m_pol);
        chk({tag, "_dvalid"},   dout_valid, e_dv);
        chk({tag, "_sof"},      sof,        e_sof);
        chk({tag, "_lost"},     lock_lost,  e_ll);
        chk({tag, "_dout"},     dout,       m_dout);
    endtask

    task automatic do_reset();
        din_valid = 1'b0; din = 8'h00;
        rst_n = 1'b0;
        #2;
        chk("rst_locked", locked, 0);
        chk("rst_inverted", inverted, 0);
        chk("rst_dvalid", dout_valid, 0);
        chk("rst_sof", sof, 0);
        chk("rst_lost", lock_lost, 0);
        chk("rst_dout", dout, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic send(input string tag, input bit v, input logic [7:0] d);
        din_valid = v; din = d;
        @(posedge clk);
        model_step(v, d);
        #1;
        model_cmp(tag);
    endtask

    task automatic frame(input string tag, input logic [7:0] s, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] c);
        send(tag, 1'b1, s); send(tag, 1'b1, a); send(tag, 1'b1, b); send(tag, 1'b1, c);
    endtask

    typedef struct {
        bit rst; bit v; logic [7:0] d;
        bit lk; bit dv; logic [7:0] o; bit sf; bit inv; bit ll;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit v, logic [7:0] d, bit lk, bit dv,
                                logic [7:0] o, bit sf, bit inv, bit ll);
        vec_t t;
        t.rst = rst; t.v = v; t.d = d; t.lk = lk; t.dv = dv;
        t.o = o; t.sf = sf; t.inv = inv; t.ll = ll;
        return t;
    endfunction

    initial begin
        model_reset();

        // True-polarity lock and payload
        tbl.push_back(mk(1, 1, 8'hA5, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h11, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h22, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h33, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hA5, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h44, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h55, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h66, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hA5, 1, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h77, 1, 1, 8'h77, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'h88, 1, 1, 8'h88, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h99, 1, 1, 8'h99, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'hA5, 1, 0, 8'h00, 0, 0, 0));
        // Inverted-polarity lock and corrected payload
        tbl.push_back(mk(1, 1, 8'h5A, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hEE, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hDD, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hCC, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h5A, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hBB, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hAA, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h99, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h5A, 1, 0, 8'h00, 0, 1, 0));
        tbl.push_back(mk(0, 1, 8'h88, 1, 1, 8'h77, 1, 1, 0));
        tbl.push_back(mk(0, 1, 8'h66, 1, 1, 8'h99, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 1, 0));

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            din_valid = tbl[i].v; din = tbl[i].d;
            @(posedge clk);
            model_step(tbl[i].v, tbl[i].d);
            #1;
            chk("tbl_locked", locked, tbl[i].lk);
            chk("tbl_dvalid", dout_valid, tbl[i].dv);
            chk("tbl_sof", sof, tbl[i].sf);
            chk("tbl_inverted", inverted, tbl[i].inv);
            chk("tbl_lost", lock_lost, tbl[i].ll);
            if (tbl[i].dv) chk("tbl_dout", dout, tbl[i].o);
        end

        // Missed sync slots: one miss is tolerated, two consecutive drop lock
        do_reset();
        frame("miss", PAT, 8'h11, 8'h22, 8'h33);
        frame("miss", PAT, 8'h11, 8'h22, 8'h33);
        frame("miss", PAT, 8'h11, 8'h22, 8'h33);
        frame("miss", 8'h00, 8'h44, 8'h55, 8'h66);
        chk("miss_one_locked", locked, 1);
        frame("miss", PAT, 8'h44, 8'h55, 8'h66);
        frame("miss", 8'h00, 8'h44, 8'h55, 8'h66);
        chk("miss_cleared_locked", locked, 1);
        send("miss", 1'b1, 8'h5A);
        chk("miss_lost_pulse", lock_lost, 1);
        chk("miss_unlocked", locked, 0);
        send("miss", 1'b1, 8'h12);
        chk("miss_pulse_end", lock_lost, 0);
        chk("miss_no_fwd", dout_valid, 0);
        send("miss", 1'b1, 8'h34);
        chk("miss_no_fwd2", dout_valid, 0);

        // Polarity flip during confirmation restarts the count
        do_reset();
        frame("flip", PAT, 8'h11, 8'h22, 8'h33);
        frame("flip", 8'h5A, 8'h11, 8'h22, 8'h33);
        frame("flip", 8'h5A, 8'h11, 8'h22, 8'h33);
        chk("flip_not_yet", locked, 0);
        send("flip", 1'b1, 8'h5A);
        chk("flip_locked", locked, 1);
        chk("flip_inverted", inverted, 1);

        // Gaps in din_valid inside a locked frame, then a mid-frame reset
        do_reset();
        frame("gap", PAT, 8'h11, 8'h22, 8'h33);
        frame("gap", PAT, 8'h11, 8'h22, 8'h33);
        frame("gap", PAT, 8'h11, 8'h22, 8'h33);
        send("gap", 1'b1, PAT);
        send("gap", 1'b0, PAT);
        send("gap", 1'b1, 8'h41);
        send("gap", 1'b0, 8'h00);
        send("gap", 1'b1, 8'h42);
        send("gap", 1'b1, 8'h43);
        send("gap", 1'b1, PAT);
        send("gap", 1'b1, 8'h51);
        chk("gap_sof", sof, 1);
        chk("gap_dout", dout, 8'h51);
        send("gap", 1'b1, 8'h52);
        chk("gap_pre_rst_locked", locked, 1);
        do_reset();
        frame("relock", 8'h52, 8'h53, PAT, 8'h11);
        frame("relock", 8'h22, 8'h33, PAT, 8'h11);
        chk("relock_not_yet", locked, 0);
        send("relock", 1'b1, 8'h22);
        send("relock", 1'b1, 8'h33);
        send("relock", 1'b1, PAT);
        chk("relock_locked", locked, 1);

        // Randomized framed stream with polarity changes, slips and junk sync slots
        do_reset();
        begin
            int k;
            bit psrc;
            k = 0; psrc = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                bit v;
                int r;
                logic [7:0] w;
                v = ($urandom_range(0, 4) != 0);
                if (k % FLEN == 0) begin
                    r = $urandom_range(0, 19);
                    if (r < 15) w = psrc ? ~PAT : PAT;
                    else if (r < 17) w = psrc ? PAT : ~PAT;
                    else w = 8'($urandom);
                end else begin
                    w = 8'($urandom);
                end
                if ($urandom_range(0, 199) == 0) psrc = ~psrc;
                if ($urandom_range(0, 149) == 0) k++;
                send("rnd", v, w);
                if (v) k++;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
